uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Configurable data width,
//  parity and stop-bit count; reports parity error, framing error and line break.
//  Sits between the async i_Rx_Serial pin and the command decoder, one clock domain.
// PARAMETERS
//  CLKS_PER_BIT  139  clocks per bit = f(i_Clock)/baud; must be >= 8
//  DATA_BITS     8    data bits per frame, 5..9, LSB first
//  PARITY        0    0 = none, 1 = odd, 2 = even
//  STOP_BITS     1    1 or 2
// PORTS
//  i_Clock        in   1          single clock, all logic on posedge
//  i_Reset        in   1          synchronous, active-high reset
//  i_Rx_Serial    in   1          async serial line, idle high
//  o_Rx_DV        out  1          one-cycle pulse: frame done, byte and flags valid
//  o_Rx_Byte      out  DATA_BITS  received data, held until next o_Rx_DV
//  o_Parity_Err   out  1          parity mismatch; valid with o_Rx_DV, 0 when PARITY=0
//  o_Frame_Err    out  1          a stop bit sampled low; valid with o_Rx_DV
//  o_Break        out  1          level: all data, parity and stop bits low; cleared when line returns high
// BEHAVIOUR
//  - Reset: all outputs 0, FSM -> IDLE, counters 0, sync flops 1. Reset mid-frame aborts the frame; no o_Rx_DV.
//  - Input passes 2-FF synchroniser (2-cycle latency) before FSM sees it.
//  - Counter width $clog2(CLKS_PER_BIT); bit index width $clog2(DATA_BITS+1).
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> CLEANUP -> IDLE; BREAK_WAIT on error.
//    IDLE:   count=0; synced line 0 -> START.
//    START:  at count==(CLKS_PER_BIT-1)/2 line still 0 -> DATA, count=0; else glitch -> IDLE.
//    DATA:   sample at count==CLKS_PER_BIT-1 into o_Rx_Byte[idx]; after DATA_BITS samples
//            -> PARITY if PARITY!=0, else STOP.
//    PARITY: sample one bit; err = (XOR(data)^bit) != (PARITY==1).
//    STOP:   sample STOP_BITS bits; any sampled 0 sets frame error.
//            After last stop sample: o_Rx_DV=1 for one cycle, flags updated, -> CLEANUP.
//    CLEANUP: one cycle, DV=0. Frame error -> BREAK_WAIT, else IDLE.
//    BREAK_WAIT: stay until synced line 1, then IDLE; o_Break cleared on exit.
//  - DV asserts at centre of last stop bit + 1 cycle, so a back-to-back start edge is never missed.
//  - o_Break set with DV when data==0, parity bit (if any) 0 and frame error set; implies o_Frame_Err.
//  - Error flags are not sticky: updated on every DV.
// CONFIGURATION
//  `UART_RX_MAJORITY_EN defined: each data/parity/stop sample is the 2-of-3 majority of synced line
//    at count CLKS_PER_BIT-2, -1 and the sample point (3-bit shift of last samples); start check unchanged.
//  Undefined: single sample at count==CLKS_PER_BIT-1; identical timing; no shift register built.
// STRUCTURE
//  uart_defs.vh: FSM state localparams (3-bit), PARITY_NONE/ODD/EVEN constants.
//  Sub-module uart_rx_sampler: 2-FF synchroniser plus optional majority voter; outputs synced line
//  and voted bit. FSM, counters and flags stay in uart_rx_cfg.
// TESTING (sim with CLKS_PER_BIT=16)
//  1. 8N1, send 0xA5 -> one DV pulse, o_Rx_Byte=0xA5, all flags 0; DV 2 + 9.5*16 cycles after start edge.
//  2. DATA_BITS=7, PARITY=2, send 0x55 with parity bit 1 -> o_Parity_Err=1; parity bit 0 -> Err=0.
//  3. STOP_BITS=2, second stop bit driven low -> o_Frame_Err=1, FSM waits in BREAK_WAIT until line high.
//  4. Line held low 20 bit times -> DV once, byte 0x00, o_Frame_Err=1, o_Break=1 until line rises.
//  5. 6-cycle low glitch on idle line -> no DV, FSM back in IDLE; next 0x3C received correctly.
//  6. Assert i_Reset during bit 4 of 0xFF -> no DV, outputs 0; following frame 0x81 received intact.

Source files
------------

// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_rx_cfg_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StCleanup,
      StBreakWait
   } rx_state_e;

   localparam int unsigned ParityNone = 0;
   localparam int unsigned ParityOdd  = 1;
   localparam int unsigned ParityEven = 2;

   // Odd parity expects data^bit == 1, even expects 0.
   function automatic logic parity_err(input logic data_xor, input logic par_bit,
                                       input int unsigned mode);
      if (mode == ParityNone) return 1'b0;
      return (data_xor ^ par_bit) != (mode == ParityOdd);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser with optional 2-of-3 majority voter (UART_RX_MAJORITY_EN).
module uart_rx_sampler (
   input  logic clk,
   input  logic rst,
   input  logic serial,
   output logic synced,
   output logic voted
);

   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], serial};
   end

   assign synced = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
   // Two previous synced values plus the current one form the vote window.
   logic [1:0] hist_q;

   always_ff @(posedge clk) begin
      if (rst) hist_q <= 2'b11;
      else     hist_q <= {hist_q[0], synced};
   end

   assign voted = (hist_q[1] & hist_q[0]) | (hist_q[1] & synced) | (hist_q[0] & synced);
`else
   assign voted = synced;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS/PARITY/STOP_BITS, parity/framing/break reporting.
// Majority sampling is enabled with the UART_RX_MAJORITY_EN macro.
module uart_rx_cfg
   import uart_rx_cfg_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 139,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
   localparam logic [CntW-1:0] SampleCnt = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfCnt   = CntW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IdxW-1:0] LastIdx   = IdxW'(DATA_BITS - 1);

   logic synced, voted;

   uart_rx_sampler u_sampler (
      .clk    (i_Clock),
      .rst    (i_Reset),
      .serial (i_Rx_Serial),
      .synced (synced),
      .voted  (voted)
   );

   rx_state_e            state_q, state_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [DATA_BITS-1:0] byte_q, byte_d;
   logic                 par_q, par_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 stop_err_q, stop_err_d;
   logic                 dv_q, dv_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 brk_q, brk_d;
   logic                 stop_err_nx, last_stop, at_sample;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q    <= StIdle;
         count_q    <= '0;
         idx_q      <= '0;
         data_q     <= '0;
         byte_q     <= '0;
         par_q      <= 1'b0;
         stop_idx_q <= 1'b0;
         stop_err_q <= 1'b0;
         dv_q       <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         brk_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         byte_q     <= byte_d;
         par_q      <= par_d;
         stop_idx_q <= stop_idx_d;
         stop_err_q <= stop_err_d;
         dv_q       <= dv_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         brk_q      <= brk_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      idx_d       = idx_q;
      data_d      = data_q;
      byte_d      = byte_q;
      par_d       = par_q;
      stop_idx_d  = stop_idx_q;
      stop_err_d  = stop_err_q;
      dv_d        = 1'b0;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      brk_d       = brk_q;
      at_sample   = (count_q == SampleCnt);
      stop_err_nx = stop_err_q | ~voted;
      last_stop   = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;

      unique case (state_q)
         StIdle: begin
            count_d    = '0;
            idx_d      = '0;
            par_d      = 1'b0;
            stop_idx_d = 1'b0;
            stop_err_d = 1'b0;
            if (!synced) state_d = StStart;
         end
         StStart: begin
            if (count_q == HalfCnt) begin
               count_d = '0;
               state_d = synced ? StIdle : StData;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         StData: begin
            if (at_sample) begin
               count_d = '0;
               // LSB arrives first, so shift right and it lands in bit 0.
               data_d  = {voted, data_q[DATA_BITS-1:1]};
               if (idx_q == LastIdx) begin
                  idx_d   = '0;
                  state_d = (PARITY != ParityNone) ? StParity : StStop;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         StParity: begin
            if (at_sample) begin
               count_d = '0;
               par_d   = voted;
               state_d = StStop;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         StStop: begin
            if (at_sample) begin
               count_d = '0;
               if (last_stop) begin
                  dv_d    = 1'b1;
                  byte_d  = data_q;
                  perr_d  = parity_err(^data_q, par_q, PARITY);
                  ferr_d  = stop_err_nx;
                  brk_d   = stop_err_nx && (data_q == '0) && !par_q;
                  state_d = StCleanup;
               end else begin
                  stop_idx_d = 1'b1;
                  stop_err_d = stop_err_nx;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         StCleanup: state_d = ferr_q ? StBreakWait : StIdle;
         StBreakWait: begin
            if (synced) begin
               brk_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign o_Rx_DV      = dv_q;
   assign o_Rx_Byte    = byte_q;
   assign o_Parity_Err = perr_q;
   assign o_Frame_Err  = ferr_q;
   assign o_Break      = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7E1 and 8N2 instances at 16 clocks per bit.
module tb_uart_rx_cfg;

   localparam int Cpb = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] rx  = 3'b111;
   int         cyc = 0;
   int         start_cyc = 0;
   int         checks = 0;
   int         errors = 0;

   logic       dv0, pe0, fe0, bk0;
   logic [7:0] by0;
   logic       dv1, pe1, fe1, bk1;
   logic [6:0] by1;
   logic       dv2, pe2, fe2, bk2;
   logic [7:0] by2;

   int dv_cnt0 = 0, dv_cnt1 = 0, dv_cnt2 = 0, dv_cyc0 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dv0) begin
         dv_cnt0 = dv_cnt0 + 1;
         dv_cyc0 = cyc;
      end
      if (dv1) dv_cnt1 = dv_cnt1 + 1;
      if (dv2) dv_cnt2 = dv_cnt2 + 1;
   end

   uart_rx_cfg #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv0), .o_Rx_Byte(by0),
      .o_Parity_Err(pe0), .o_Frame_Err(fe0), .o_Break(bk0)
   );

   uart_rx_cfg #(.CLKS_PER_BIT(Cpb), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut1 (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv1), .o_Rx_Byte(by1),
      .o_Parity_Err(pe1), .o_Frame_Err(fe1), .o_Break(bk1)
   );

   uart_rx_cfg #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut2 (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv2), .o_Rx_Byte(by2),
      .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Break(bk2)
   );

   // Called on a negedge; every bit is held for Cpb clocks.
   task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                             input bit has_par, input logic par, input int nstop,
                             input logic stop_last);
      rx[sel] = 1'b0;
      start_cyc = cyc;
      repeat (Cpb) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         rx[sel] = data[i];
         repeat (Cpb) @(negedge clk);
      end
      if (has_par) begin
         rx[sel] = par;
         repeat (Cpb) @(negedge clk);
      end
      for (int i = 0; i < nstop; i++) begin
         rx[sel] = (i == nstop - 1) ? stop_last : 1'b1;
         repeat (Cpb) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL reset_dv got %b exp 0", dv0); end
      checks++; if (by0 !== 8'h00) begin errors++; $display("FAIL reset_byte got %h exp 00", by0); end
      checks++; if (pe0 !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", pe0); end
      checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", fe0); end
      checks++; if (bk0 !== 1'b0) begin errors++; $display("FAIL reset_brk got %b exp 0", bk0); end
      checks++; if (by1 !== 7'h00) begin errors++; $display("FAIL reset_byte1 got %h exp 00", by1); end
      rst = 1'b0;
      repeat (Cpb) @(negedge clk);
   endtask

   task automatic test_8n1();
      int n, lat;
      n = dv_cnt0;
      send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
      repeat (4) @(negedge clk);
      lat = dv_cyc0 - start_cyc;
      checks++; if (dv_cnt0 - n !== 1) begin errors++; $display("FAIL 8n1_dv_count got %0d exp 1", dv_cnt0 - n); end
      checks++; if (by0 !== 8'hA5) begin errors++; $display("FAIL 8n1_byte got %h exp a5", by0); end
      checks++; if ({pe0, fe0, bk0} !== 3'b000) begin errors++; $display("FAIL 8n1_flags got %b exp 000", {pe0, fe0, bk0}); end
      checks++; if (lat < 152 || lat > 158) begin errors++; $display("FAIL 8n1_latency got %0d exp 152..158", lat); end
   endtask

   task automatic test_parity();
      int n;
      n = dv_cnt1;
      send_frame(1, 9'h055, 7, 1'b1, 1'b1, 1, 1'b1);
      repeat (4) @(negedge clk);
      checks++; if (dv_cnt1 - n !== 1) begin errors++; $display("FAIL par_bad_dv got %0d exp 1", dv_cnt1 - n); end
      checks++; if (by1 !== 7'h55) begin errors++; $display("FAIL par_bad_byte got %h exp 55", by1); end
      checks++; if (pe1 !== 1'b1) begin errors++; $display("FAIL par_bad_err got %b exp 1", pe1); end
      send_frame(1, 9'h055, 7, 1'b1, 1'b0, 1, 1'b1);
      repeat (4) @(negedge clk);
      checks++; if (pe1 !== 1'b0) begin errors++; $display("FAIL par_good_err got %b exp 0", pe1); end
      checks++; if (fe1 !== 1'b0) begin errors++; $display("FAIL par_good_ferr got %b exp 0", fe1); end
      send_frame(1, 9'h013, 7, 1'b1, 1'b1, 1, 1'b1);
      repeat (4) @(negedge clk);
      checks++; if ({by1, pe1} !== {7'h13, 1'b0}) begin errors++; $display("FAIL par_odd_data got %h/%b exp 13/0", by1, pe1); end
   endtask

   task automatic test_two_stop();
      int n;
      n = dv_cnt2;
      send_frame(2, 9'h03A, 8, 1'b0, 1'b0, 2, 1'b0);
      repeat (200) @(negedge clk);
      checks++; if (dv_cnt2 - n !== 1) begin errors++; $display("FAIL stop2_dv_count got %0d exp 1", dv_cnt2 - n); end
      checks++; if (by2 !== 8'h3A) begin errors++; $display("FAIL stop2_byte got %h exp 3a", by2); end
      checks++; if ({fe2, bk2} !== 2'b10) begin errors++; $display("FAIL stop2_flags got %b exp 10", {fe2, bk2}); end
      rx[2] = 1'b1;
      repeat (2 * Cpb) @(negedge clk);
      send_frame(2, 9'h05C, 8, 1'b0, 1'b0, 2, 1'b1);
      repeat (4) @(negedge clk);
      checks++; if (dv_cnt2 - n !== 2) begin errors++; $display("FAIL stop2_next_dv got %0d exp 2", dv_cnt2 - n); end
      checks++; if ({by2, fe2} !== {8'h5C, 1'b0}) begin errors++; $display("FAIL stop2_next got %h/%b exp 5c/0", by2, fe2); end
   endtask

   task automatic test_break();
      int n;
      n = dv_cnt0;
      rx[0] = 1'b0;
      repeat (20 * Cpb) @(negedge clk);
      checks++; if (dv_cnt0 - n !== 1) begin errors++; $display("FAIL brk_dv_count got %0d exp 1", dv_cnt0 - n); end
      checks++; if (by0 !== 8'h00) begin errors++; $display("FAIL brk_byte got %h exp 00", by0); end
      checks++; if ({fe0, bk0} !== 2'b11) begin errors++; $display("FAIL brk_flags got %b exp 11", {fe0, bk0}); end
      rx[0] = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (bk0 !== 1'b0) begin errors++; $display("FAIL brk_clear got %b exp 0", bk0); end
      repeat (2 * Cpb) @(negedge clk);
   endtask

   task automatic test_glitch();
      int n;
      n = dv_cnt0;
      rx[0] = 1'b0;
      repeat (6) @(negedge clk);
      rx[0] = 1'b1;
      repeat (3 * Cpb) @(negedge clk);
      checks++; if (dv_cnt0 - n !== 0) begin errors++; $display("FAIL glitch_dv got %0d exp 0", dv_cnt0 - n); end
      send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
      repeat (4) @(negedge clk);
      checks++; if (dv_cnt0 - n !== 1) begin errors++; $display("FAIL glitch_next_dv got %0d exp 1", dv_cnt0 - n); end
      checks++; if ({by0, fe0, bk0} !== {8'h3C, 2'b00}) begin errors++; $display("FAIL glitch_next got %h/%b%b exp 3c/00", by0, fe0, bk0); end
   endtask

   task automatic test_reset_mid();
      int n;
      n = dv_cnt0;
      rx[0] = 1'b0;
      repeat (Cpb) @(negedge clk);
      rx[0] = 1'b1;
      repeat (4 * Cpb + Cpb / 2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4 * Cpb + 20) @(negedge clk);
      checks++; if (dv_cnt0 - n !== 0) begin errors++; $display("FAIL rstmid_dv got %0d exp 0", dv_cnt0 - n); end
      checks++; if ({by0, pe0, fe0, bk0} !== 11'h000) begin errors++; $display("FAIL rstmid_out got %h/%b%b%b exp 00/000", by0, pe0, fe0, bk0); end
      send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1);
      repeat (4) @(negedge clk);
      checks++; if (dv_cnt0 - n !== 1) begin errors++; $display("FAIL rstmid_next_dv got %0d exp 1", dv_cnt0 - n); end
      checks++; if (by0 !== 8'h81) begin errors++; $display("FAIL rstmid_next_byte got %h exp 81", by0); end
   endtask

   task automatic test_back_to_back();
      int n;
      n = dv_cnt0;
      send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1);
      checks++; if (by0 !== 8'h12) begin errors++; $display("FAIL b2b_first got %h exp 12", by0); end
      send_frame(0, 9'h034, 8, 1'b0, 1'b0, 1, 1'b1);
      repeat (4) @(negedge clk);
      checks++; if (by0 !== 8'h34) begin errors++; $display("FAIL b2b_second got %h exp 34", by0); end
      checks++; if (dv_cnt0 - n !== 2) begin errors++; $display("FAIL b2b_dv_count got %0d exp 2", dv_cnt0 - n); end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_two_stop();
      test_break();
      test_glitch();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
